// File: rtl/i2s_tx.sv
// ---------------------------------------------------------------------------
// i2s_tx - stereo I2S transmitter for the headphone/amplifier DAC.
//
// Runs entirely in the pixel clock domain. A 26-bit fractional phase
// accumulator produces an 'edge' pulse at exactly 64 * SAMPLE_RATE per
// second for both the PAL and NTSC pixel clocks. Each edge toggles hp_bck.
// All data movement (word select, serial data, word load) happens on the
// falling bck toggle, so the receiver sees stable data on the rising edge.
//
// Frame layout (32 bck periods, standard I2S one-bit delay after ws):
//   slot 0      : previous R[0]  (ws = 0)
//   slots 1..15 : L[15..1]       (ws = 0)
//   slot 16     : L[0]           (ws = 1)
//   slots 17..31: R[15..1]       (ws = 1)
//
// Optional feature macro: I2S_MONO_MIX_EN
//   defined   -> both words carry (sext(L) + sext(R)) >>> 1 (mono average)
//   undefined -> true stereo, L and R passed through unmodified
//
// pll_lock doubles as the asynchronous active-low reset: while the pixel
// PLL is unlocked the transmitter is held idle with all outputs low.
// ---------------------------------------------------------------------------
module i2s_tx #(
    parameter int CLK_HZ_PAL  = 31500000,
    parameter int CLK_HZ_NTSC = 32940000,
    parameter int SAMPLE_RATE = 24000
) (
    input  logic        clk,
    input  logic        pll_lock,
    input  logic        ntscmode,
    input  logic [15:0] audio_l,
    input  logic [15:0] audio_r,
    output logic        sample_strobe,
    output logic        hp_bck,
    output logic        hp_ws,
    output logic        hp_din
);

    // Two bck toggles per bit, 32 bits per frame -> 64 edges per frame.
    localparam logic [25:0] STEP     = 26'(64 * SAMPLE_RATE);
    localparam logic [25:0] MOD_PAL  = 26'(CLK_HZ_PAL);
    localparam logic [25:0] MOD_NTSC = 26'(CLK_HZ_NTSC);

    // Slot counter value after the last slot of a frame; the next falling
    // edge wraps it to zero and starts a new frame.
    localparam logic [4:0]  LAST_SLOT = 5'd31;

`ifdef I2S_MONO_MIX_EN
    // Average of the two channels. The 17-bit sum cannot overflow, and the
    // arithmetic shift brings it back into 16-bit range, so bits [16:1] of
    // the sum are exactly the shifted, truncated result.
    function automatic logic [15:0] mono_mix(input logic [15:0] left,
                                             input logic [15:0] right);
        logic signed [16:0] sum;
        sum = $signed({left[15], left}) + $signed({right[15], right});
        return sum[16:1];
    endfunction
`endif

    // Accumulator state and next-state terms.
    logic [25:0] acc_r;
    logic [25:0] mod_s;
    logic [25:0] sum_s;
    logic [25:0] acc_nxt_s;
    logic        edge_s;

    // Serializer state.
    logic [4:0]  bit_cnt_r;
    logic [4:0]  bit_cnt_nxt_s;
    logic [31:0] sr_r;
    logic [31:0] word_s;
    logic        fall_s;
    logic        frame_start_s;

    // Phase accumulator next state: the modulus follows ntscmode directly,
    // so a mode change applies on the very next clk. If the accumulator is
    // already above the new (smaller) modulus the subtract branch fires
    // once and lands below the modulus again, so no lockup is possible.
    always_comb begin
        mod_s     = MOD_PAL;
        sum_s     = acc_r + STEP;
        acc_nxt_s = sum_s;
        edge_s    = 1'b0;
        if (ntscmode) begin
            mod_s = MOD_NTSC;
        end else begin
            mod_s = MOD_PAL;
        end
        if (sum_s >= mod_s) begin
            acc_nxt_s = sum_s - mod_s;
            edge_s    = 1'b1;
        end else begin
            acc_nxt_s = sum_s;
            edge_s    = 1'b0;
        end
    end

    // Falling-edge decode and the word to load at the start of a frame.
    always_comb begin
        fall_s        = edge_s & hp_bck;
        bit_cnt_nxt_s = bit_cnt_r + 5'd1;
        frame_start_s = fall_s & (bit_cnt_r == LAST_SLOT);
`ifdef I2S_MONO_MIX_EN
        word_s        = {mono_mix(audio_l, audio_r), mono_mix(audio_l, audio_r)};
`else
        word_s        = {audio_l, audio_r};
`endif
    end

    // Phase accumulator register.
    always_ff @(posedge clk or negedge pll_lock) begin
        if (!pll_lock) begin
            acc_r <= 26'd0;
        end else begin
            acc_r <= acc_nxt_s;
        end
    end

    // Bit clock: toggles once per accumulator edge.
    always_ff @(posedge clk or negedge pll_lock) begin
        if (!pll_lock) begin
            hp_bck <= 1'b0;
        end else if (edge_s) begin
            hp_bck <= ~hp_bck;
        end else begin
            hp_bck <= hp_bck;
        end
    end

    // Serializer: on each falling bck, advance the slot, update ws and shift
    // out the next data bit. At the frame boundary the shift register is
    // reloaded instead of shifted; hp_din still takes the old MSB, which is
    // the previous frame's R[0] (the I2S one-bit delay).
    always_ff @(posedge clk or negedge pll_lock) begin
        if (!pll_lock) begin
            bit_cnt_r <= LAST_SLOT;
            hp_ws     <= 1'b0;
            hp_din    <= 1'b0;
            sr_r      <= 32'd0;
        end else if (fall_s) begin
            bit_cnt_r <= bit_cnt_nxt_s;
            hp_ws     <= bit_cnt_nxt_s[4];
            hp_din    <= sr_r[31];
            if (bit_cnt_nxt_s == 5'd0) begin
                sr_r <= word_s;
            end else begin
                sr_r <= {sr_r[30:0], 1'b0};
            end
        end else begin
            bit_cnt_r <= bit_cnt_r;
            hp_ws     <= hp_ws;
            hp_din    <= hp_din;
            sr_r      <= sr_r;
        end
    end

    // Capture acknowledge: one clk high together with the frame-start
    // falling edge at which the sample words are loaded.
    always_ff @(posedge clk or negedge pll_lock) begin
        if (!pll_lock) begin
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= frame_start_s;
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx - directed self-checking bench for i2s_tx.
// Covers PAL/NTSC bck rates, first-edge latency, strobe placement, I2S
// framing, mid-run mode switch, mid-frame reset and (with I2S_MONO_MIX_EN)
// the mono mix values.
// ---------------------------------------------------------------------------
module tb_i2s_tx;

    logic        clk;
    logic        pll_lock;
    logic        ntscmode;
    logic [15:0] audio_l;
    logic [15:0] audio_r;
    logic        sample_strobe;
    logic        hp_bck;
    logic        hp_ws;
    logic        hp_din;

    int errors;
    int checks;
    int cyc;
    int edges;
    int strobes;
    int first_edge_cyc;
    int strobe_edge;
    logic bck_prev;

    i2s_tx dut (
        .clk           (clk),
        .pll_lock      (pll_lock),
        .ntscmode      (ntscmode),
        .audio_l       (audio_l),
        .audio_r       (audio_r),
        .sample_strobe (sample_strobe),
        .hp_bck        (hp_bck),
        .hp_ws         (hp_ws),
        .hp_din        (hp_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clk: sample 1 time unit after the rising edge, track bck toggles.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (hp_bck !== bck_prev) begin
            edges++;
            if (first_edge_cyc == 0) first_edge_cyc = cyc;
            bck_prev = hp_bck;
        end
        if (sample_strobe === 1'b1) begin
            strobes++;
            if (strobe_edge == 0) strobe_edge = edges;
        end
    endtask

    task automatic wait_edge();
        int e0;
        int n;
        e0 = edges;
        n  = 0;
        while (edges == e0 && n < 64) begin
            tick();
            n++;
        end
        if (edges == e0) begin
            checks++;
            errors++;
            $error("FAIL edge_timeout: observed no bck toggle in %0d clks, expected one", n);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        pll_lock       = 1'b1;
        cyc            = 0;
        edges          = 0;
        strobes        = 0;
        first_edge_cyc = 0;
        strobe_edge    = 0;
        bck_prev       = 1'b0;
    endtask

    task automatic do_reset(input logic mode);
        pll_lock = 1'b0;
        ntscmode = mode;
        repeat (5) @(posedge clk);
        release_reset();
    endtask

    // Called just after the falling edge entering slot 0; samples every
    // slot on rising bck through the next frame's slot 0.
    task automatic read_frame(output logic [31:0] word, output logic [31:0] wsw,
                              output logic slot0, output logic slot0_next);
        logic [32:0] d;
        logic [32:0] w;
        d    = 33'd0;
        w    = 33'd0;
        word = 32'd0;
        wsw  = 32'd0;
        for (int s = 0; s <= 32; s++) begin
            wait_edge();
            d[s] = hp_din;
            w[s] = hp_ws;
            if (s < 32) wait_edge();
        end
        for (int s = 1; s <= 31; s++) word[32 - s] = d[s];
        word[0] = d[32];
        for (int s = 0; s <= 31; s++) wsw[31 - s] = w[s];
        slot0      = d[0];
        slot0_next = d[32];
    endtask

    task automatic frame_test(input string tag, input logic [15:0] l, input logic [15:0] r,
                              input logic [31:0] exp_word);
        logic [31:0] word;
        logic [31:0] wsw;
        logic        s0;
        logic        s0n;
        audio_l = l;
        audio_r = r;
        do_reset(1'b0);
        repeat (66) wait_edge();
        read_frame(word, wsw, s0, s0n);
        check({tag, "_word"}, word, exp_word);
        check({tag, "_ws"}, wsw, 32'h0000FFFF);
        check({tag, "_slot0"}, {31'd0, s0}, {31'd0, exp_word[0]});
        check({tag, "_slot16"}, {31'd0, word[16]}, {31'd0, exp_word[16]});
        check({tag, "_next_slot0"}, {31'd0, s0n}, {31'd0, exp_word[0]});
    endtask

    initial begin
        int last;
        errors         = 0;
        checks         = 0;
        cyc            = 0;
        edges          = 0;
        strobes        = 0;
        first_edge_cyc = 0;
        strobe_edge    = 0;
        bck_prev       = 1'b0;
        pll_lock       = 1'b0;
        ntscmode       = 1'b0;
        audio_l        = 16'hA5C3;
        audio_r        = 16'h3C5A;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {28'd0, hp_bck, hp_ws, hp_din, sample_strobe}, 32'd0);

        // PAL rate over one exact period of the accumulator.
        do_reset(1'b0);
        repeat (2625) tick();
        check("pal_toggles", edges, 32'd128);
        check("pal_strobes", strobes, 32'd2);
        check("pal_first_edge", first_edge_cyc, 32'd21);
        check("pal_strobe_edge", strobe_edge, 32'd2);

        // NTSC rate.
        do_reset(1'b1);
        repeat (2745) tick();
        check("ntsc_toggles", edges, 32'd128);
        check("ntsc_first_edge", first_edge_cyc, 32'd22);
        repeat (27450 - 2745) tick();
        check("ntsc_toggles_long", edges, 32'd1280);
        check("ntsc_frames", {31'd0, (strobes >= 19 && strobes <= 21)}, 32'd1);

        // Framing with held stereo data (mono mix of A5C3/3C5A is F10E).
`ifdef I2S_MONO_MIX_EN
        frame_test("frame_a5c3", 16'hA5C3, 16'h3C5A, 32'hF10EF10E);
        frame_test("frame_max", 16'h7FFF, 16'h7FFF, 32'h7FFF7FFF);
        frame_test("frame_mix", 16'h8000, 16'h7FFF, 32'hFFFFFFFF);
`else
        frame_test("frame_a5c3", 16'hA5C3, 16'h3C5A, 32'hA5C33C5A);
        frame_test("frame_max", 16'h7FFF, 16'h7FFF, 32'h7FFF7FFF);
        frame_test("frame_mix", 16'h8000, 16'h7FFF, 32'h80007FFF);
`endif

        // Mode switch NTSC->PAL with acc = 32256000 (> PAL modulus) after 21 clks.
        do_reset(1'b1);
        repeat (21) tick();
        check("switch_no_edge_yet", edges, 32'd0);
        ntscmode = 1'b0;
        tick();
        check("switch_edge_next_clk", edges, 32'd1);
        wait_edge();
        check("switch_edge2_clk", cyc, 32'd42);
        wait_edge();
        check("switch_edge3_clk", cyc, 32'd62);
        wait_edge();
        check("switch_edge4_clk", cyc, 32'd83);
        for (int k = 0; k < 6; k++) begin
            last = cyc;
            wait_edge();
            check("switch_pal_spacing", {31'd0, ((cyc - last) >= 20 && (cyc - last) <= 21)}, 32'd1);
        end

        // Reset mid-frame at slot 9 (carries L[7] = 1 of A5C3).
        audio_l = 16'hA5C3;
        audio_r = 16'h3C5A;
        do_reset(1'b0);
        repeat (2) wait_edge();
        repeat (18) wait_edge();
        wait_edge();
        check("slot9_state", {29'd0, hp_bck, hp_ws, hp_din}, {29'd0, 1'b1, 1'b0, 1'b1});
        #2;
        pll_lock = 1'b0;
        #1;
        check("midreset_outputs", {28'd0, hp_bck, hp_ws, hp_din, sample_strobe}, 32'd0);
        repeat (3) @(posedge clk);
        release_reset();
        repeat (60) tick();
        check("midreset_first_edge", first_edge_cyc, 32'd21);
        check("midreset_strobe_edge", strobe_edge, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
